scumv_host_packet_framer: RTL and testbench

Initiator-side counterpart of the SCuM-V controller's prefix-routing UART receiver. Accepts a command (ASC or STL) plus payload bytes, emits the framed byte stream ("asc+"/"stl+" prefix, then payload) toward a UART transmitter, then collects the fixed-length response from a UART receiver and presents it on a response stream. It is used in FPGA self-test and loopback builds, where a fabric-side master drives the controller without a host PC. A response timeout guarantees return to idle.

---
 rtl/scumv_host_packet_framer.sv | 88 ++++++++
 tb/tb_scumv_host_packet_framer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scumv_host_packet_framer.sv
// scumv_host_packet_framer: frames ASC/STL commands toward a UART TX and collects the fixed-length reply from a UART RX
module scumv_host_packet_framer #(
    parameter int ASC_PACKET_SIZE   = 22,
    parameter int STL_PACKET_SIZE   = 16,
    parameter int ASC_RESPONSE_SIZE = 1,
    parameter int STL_RESPONSE_SIZE = 16,
    parameter int TIMEOUT_CYCLES    = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_mode,
    input  logic       payload_valid,
    output logic       payload_ready,
    input  logic [7:0] payload_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [7:0] drop_count
);
    typedef enum logic [1:0] {IDLE, PREFIX, PAYLOAD, RESP} state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    state_t state, state_n;
    logic mode;
    logic [7:0] cnt, pkt_last, rsp_end;
    logic [TW-1:0] tcnt;
    logic tx_hs, rx_hs, cmd_hs, to_hit, rsp_fin;
    always_comb begin
        pkt_last = mode ? 8'(STL_PACKET_SIZE - 1) : 8'(ASC_PACKET_SIZE - 1);
        rsp_end = mode ? 8'(STL_RESPONSE_SIZE - 1) : 8'(ASC_RESPONSE_SIZE - 1);
        cmd_ready = reset && state == IDLE;
        tx_valid = reset && (state == PREFIX || (state == PAYLOAD && payload_valid));
        tx_data = state == PAYLOAD ? payload_data :
                  cnt[1:0] == 2'd0 ? (mode ? 8'h73 : 8'h61) :
                  cnt[1:0] == 2'd1 ? (mode ? 8'h74 : 8'h73) :
                  cnt[1:0] == 2'd2 ? (mode ? 8'h6C : 8'h63) : 8'h2B;
        payload_ready = reset && state == PAYLOAD && tx_ready;
        rx_ready = reset && (state == RESP ? rsp_ready : 1'b1);
        rsp_valid = reset && state == RESP && rx_valid;
        rsp_data = rx_data;
        rsp_last = state == RESP && cnt == rsp_end;
        busy = state != IDLE;
        tx_hs = tx_valid && tx_ready;
        rx_hs = rx_valid && rx_ready;
        cmd_hs = cmd_valid && cmd_ready;
        rsp_fin = state == RESP && rx_hs && cnt == rsp_end;
        // the counter hits TIMEOUT_CYCLES-1 on this idle cycle, so leave now
        to_hit = state == RESP && !rx_hs && tcnt == TW'(TIMEOUT_CYCLES - 2);
        state_n = state;
        case (state)
            IDLE:    state_n = cmd_hs ? PREFIX : IDLE;
            PREFIX:  state_n = (tx_hs && cnt == 8'd3) ? PAYLOAD : PREFIX;
            PAYLOAD: state_n = (tx_hs && cnt == pkt_last) ? RESP : PAYLOAD;
            default: state_n = (rsp_fin || to_hit) ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            mode <= 1'b0;
            cnt <= 8'd0;
            tcnt <= '0;
            done <= 1'b0;
            timeout_err <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            state <= state_n;
            done <= rsp_fin || to_hit;
            if (cmd_hs) mode <= cmd_mode;
            timeout_err <= to_hit ? 1'b1 : cmd_hs ? 1'b0 : timeout_err;
            cnt <= state_n != state ? 8'd0 :
                   (((state == PREFIX || state == PAYLOAD) && tx_hs) || (state == RESP && rx_hs)) ? cnt + 8'd1 : cnt;
            tcnt <= (state == RESP && !rx_hs && !to_hit) ? tcnt + TW'(1) : '0;
            if (state != RESP && rx_valid && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_scumv_host_packet_framer.sv
// tb_scumv_host_packet_framer: directed and randomized framing/response checks against a queue-based model
module tb_scumv_host_packet_framer;
    logic clk = 0, reset = 0;
    logic cmd_valid = 0, cmd_ready, cmd_mode = 0;
    logic payload_valid = 0, payload_ready;
    logic [7:0] payload_data = 0;
    logic tx_valid, tx_ready = 1;
    logic [7:0] tx_data;
    logic rx_valid = 0, rx_ready;
    logic [7:0] rx_data = 0;
    logic rsp_valid, rsp_ready = 1, rsp_last;
    logic [7:0] rsp_data;
    logic busy, done, timeout_err;
    logic [7:0] drop_count;

    scumv_host_packet_framer #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .payload_valid(payload_valid), .payload_ready(payload_ready), .payload_data(payload_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy), .done(done), .timeout_err(timeout_err), .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0, total = 0;
    byte unsigned pay_q[$], rx_q[$], tx_got[$], rsp_got[$];
    bit last_got[$];
    int done_cyc[$];
    int last_hs_cyc;
    bit fin;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_got.push_back(tx_data);
        if (rsp_valid && rsp_ready) begin
            rsp_got.push_back(rsp_data);
            last_got.push_back(rsp_last);
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input bit mode);
        tx_got.delete(); rsp_got.delete(); last_got.delete(); done_cyc.delete();
        cmd_valid = 1; cmd_mode = mode;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0; cmd_mode = 1'($urandom);
        @(negedge clk);
        chk("busy_after_cmd", busy, 1);
        chk("timeout_err_cleared", timeout_err, 0);
        tick();
    endtask

    task automatic run_cmd(input bit mode, input bit rnd, input int nrx);
        int n = mode ? 16 : 22;
        int r = mode ? 16 : 1;
        string pfx = mode ? "stl+" : "asc+";
        fin = 0;
        start_cmd(mode);
        fork
            begin
                int i = 0;
                bit hs;
                for (int g = 0; g < 3000 && i < n; g++) begin
                    payload_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                    payload_data = payload_valid ? pay_q[i] : 8'($urandom);
                    @(negedge clk);
                    hs = payload_valid && payload_ready;
                    tick();
                    if (hs) i++;
                end
                payload_valid = 0;
            end
            begin
                while (!fin) begin
                    tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    tick();
                end
                tx_ready = 1;
            end
            begin
                int i = 0;
                bit hs;
                for (int g = 0; g < 3000 && tx_got.size() < n + 4; g++) tick();
                for (int g = 0; g < 3000 && i < nrx; g++) begin
                    rx_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                    rx_data = rx_valid ? rx_q[i] : 8'($urandom);
                    rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    @(negedge clk);
                    hs = rx_valid && rx_ready;
                    if (hs) last_hs_cyc = cyc;
                    tick();
                    if (hs) i++;
                end
                rx_valid = 0; rsp_ready = 1;
                for (int g = 0; g < 200 && done_cyc.size() == 0; g++) tick();
                fin = 1;
            end
        join
        chk("tx_len", tx_got.size(), n + 4);
        for (int i = 0; i < tx_got.size() && i < n + 4; i++)
            chk($sformatf("tx[%0d]", i), tx_got[i], i < 4 ? pfx[i] : pay_q[i - 4]);
        chk("rsp_len", rsp_got.size(), nrx);
        for (int i = 0; i < rsp_got.size() && i < nrx; i++) begin
            chk($sformatf("rsp[%0d]", i), rsp_got[i], rx_q[i]);
            chk($sformatf("rsp_last[%0d]", i), last_got[i], nrx == r && i == r - 1);
        end
        chk("done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("done_cycle", done_cyc[0], last_hs_cyc + (nrx == r ? 1 : 50));
        chk("timeout_err", timeout_err, nrx != r);
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("cmd_ready_idle", cmd_ready, 1);
        repeat (3) tick();
        chk("single_done", done_cyc.size(), 1);
    endtask

    task automatic fill(input int n, input int r, input bit seq);
        pay_q.delete(); rx_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(seq ? 8'(i) : 8'($urandom));
        for (int i = 0; i < r; i++) rx_q.push_back(8'($urandom));
    endtask

    initial begin
        int bad_rdy, bad_rsp;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_drop_count", drop_count, 0);
        tick();
        reset = 1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_rx_ready", rx_ready, 1);
        tick();

        fill(22, 0, 1); rx_q.push_back(8'hA5);
        run_cmd(0, 0, 1);
        fill(16, 0, 0);
        for (int i = 0; i < 16; i++) rx_q.push_back(8'(8'h10 + i));
        run_cmd(1, 0, 16);
        for (int k = 0; k < 3; k++) begin
            fill(16, 16, 0);
            run_cmd(1, 1, 16);
        end
        fill(16, 3, 0);
        run_cmd(1, 0, 3);
        fill(22, 1, 0);
        run_cmd(0, 1, 1);

        chk("drop_before_stray", drop_count, 0);
        rsp_got.delete(); bad_rdy = 0; bad_rsp = 0;
        rx_valid = 1;
        for (int k = 0; k < 300; k++) begin
            rx_data = 8'($urandom);
            @(negedge clk);
            if (rx_ready !== 1'b1) bad_rdy++;
            if (rsp_valid !== 1'b0) bad_rsp++;
            tick();
            if (k == 4) chk("drop_5", drop_count, 5);
        end
        rx_valid = 0;
        chk("stray_rx_ready", bad_rdy, 0);
        chk("stray_rsp_valid", bad_rsp, 0);
        chk("stray_rsp_none", rsp_got.size(), 0);
        chk("drop_saturated", drop_count, 255);

        fill(16, 0, 0);
        start_cmd(1);
        begin
            int i = 0;
            bit hs;
            for (int g = 0; g < 500 && i < 7; g++) begin
                payload_valid = 1; payload_data = pay_q[i];
                @(negedge clk);
                hs = payload_valid && payload_ready;
                tick();
                if (hs) i++;
            end
            payload_data = pay_q[7];
        end
        chk("abort_tx_count", tx_got.size(), 11);
        reset = 0;
        tick();
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_payload_ready", payload_ready, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        tick();
        reset = 1; payload_valid = 0;
        repeat (4) tick();
        chk("abort_no_done", done_cyc.size(), 0);
        chk("abort_drop_cleared", drop_count, 0);
        fill(22, 0, 1); rx_q.push_back(8'($urandom));
        run_cmd(0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
